ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_if.sv | 30 +++
 rtl/ifetch_queue.sv | 110 +++++++++++
 tb/tb_ifetch_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: instruction-memory request/ack plus the
// decoder-facing queue head. The fetch unit is the master.
//
// Handshakes: imem_req/imem_addr stay stable until imem_ack (or a
// redirect); a word is accepted only when imem_ack and imem_req are both
// high in the same cycle. The queue head transfers when instr_valid and
// instr_ready are both high at a rising edge; instr/instr_pc hold while
// instr_valid=1 and instr_ready=0.
interface ifetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small registered instruction queue.
// One outstanding memory request at a time; redirect flushes the queue
// and restarts fetch. mode_o exposes the EMPTY/FETCH/FULL state.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    ifetch_queue_if.master    bus,
    output logic [1:0]        mode_o
);
    localparam int             PW       = (DEPTH == 4) ? 2 : 1;
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        MODE_EMPTY = 2'd0,
        MODE_FETCH = 2'd1,
        MODE_FULL  = 2'd2
    } mode_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    mode_t         mode_q, mode_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic          push;
    logic          pop;

    // Request only with a free slot; a redirect cycle never requests, so an
    // ack in that cycle can not be accepted. Reset holds the request low.
    assign bus.imem_req    = ~reset & (count_q < FULL_CNT) & ~bus.redirect;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = word_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign mode_o          = mode_q;

    assign push = bus.imem_ack & bus.imem_req;
    assign pop  = bus.instr_valid & bus.instr_ready;

    // Next-state for fetch PC, pointers and occupancy; redirect wins.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Mode follows the next occupancy so it is registered with count.
    always_comb begin
        mode_d = MODE_FETCH;
        if (count_d == '0) begin
            mode_d = MODE_EMPTY;
        end else if (count_d == FULL_CNT) begin
            mode_d = MODE_FULL;
        end
    end

    // Control state: fetch PC, pointers, occupancy and mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mode_q     <= MODE_EMPTY;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mode_q     <= mode_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            word_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a directed vector table on the default
// instance, hand sequences for asynchronous reset, PC wrap and a
// four-entry queue.
module tb_ifetch_queue;
    logic clk;
    logic rst;
    logic rst_b;
    logic [1:0] mode1, mode2, mode3;

    int n_vec;
    int n_err;

    ifetch_queue_if if1 ();
    ifetch_queue_if if2 ();
    ifetch_queue_if if3 ();

    ifetch_queue dut (.clk(clk), .reset(rst), .bus(if1), .mode_o(mode1));
    ifetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .reset(rst_b), .bus(if2), .mode_o(mode2));
    ifetch_queue #(.DEPTH(4)) dut3 (.clk(clk), .reset(rst_b), .bus(if3), .mode_o(mode3));

    // Memories for the hand sequences answer with the address as data.
    assign if2.imem_rdata = if2.imem_addr;
    assign if3.imem_rdata = if3.imem_addr;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic rd, input logic [31:0] rp, input logic rdy,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.redir = rd; v.rpc = rp; v.ready = rdy;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        rst_b = 1'b1;
        if1.imem_ack = 1'b0; if1.imem_rdata = '0; if1.redirect = 1'b0;
        if1.redirect_pc = '0; if1.instr_ready = 1'b0;
        if2.imem_ack = 1'b1; if2.redirect = 1'b0; if2.redirect_pc = '0; if2.instr_ready = 1'b1;
        if3.imem_ack = 1'b1; if3.redirect = 1'b0; if3.redirect_pc = '0; if3.instr_ready = 1'b0;

        //                 rst ack rdata          rd rpc            rdy  req addr           vld instr          pc
        // reset, ack ignored
        tbl.push_back(mk(1, 1, 32'h0000_DEAD, 0, 32'h0,         1,   0, 32'h0000_0000, 0, 32'h0,         32'h0));
        // streaming: one per cycle, instr == pc
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 32'h0,         1,   1, 32'h0000_0008, 1, 32'h4,         32'h4));
        tbl.push_back(mk(0, 1, 32'h0000_000C, 0, 32'h0,         1,   1, 32'h0000_000C, 1, 32'h8,         32'h8));
        // reset with a non-empty queue
        tbl.push_back(mk(1, 1, 32'h0000_0010, 0, 32'h0,         1,   0, 32'h0000_0000, 0, 32'h0,         32'h0));
        // decoder stalled: queue fills to two, request drops
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 32'h0,         0,   1, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0004, 0, 32'h0,         0,   1, 32'h0000_0004, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0099, 0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         0,   0, 32'h0000_0008, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   0, 32'h0000_0008, 1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0008, 0, 32'h0,         1,   1, 32'h0000_0008, 1, 32'h4,         32'h4));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         0,   1, 32'h0000_000C, 1, 32'h8,         32'h8));
        tbl.push_back(mk(0, 1, 32'h0000_000C, 0, 32'h0,         0,   1, 32'h0000_000C, 1, 32'h8,         32'h8));
        // redirect to 0x103 with two entries queued and ack high
        tbl.push_back(mk(0, 1, 32'h0000_0BAD, 1, 32'h0000_0103, 1,   0, 32'h0000_0010, 1, 32'h8,         32'h8));
        tbl.push_back(mk(0, 1, 32'h0000_0100, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0104, 1, 32'h100,       32'h100));
        // back-to-back redirects: last wins
        tbl.push_back(mk(0, 0, 32'h0000_0000, 1, 32'h0000_0200, 1,   0, 32'h0000_0104, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 1, 32'h0000_030A, 1,   0, 32'h0000_0200, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0308, 0, 32'h0,         1,   1, 32'h0000_0308, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         0,   1, 32'h0000_030C, 1, 32'h308,       32'h308));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_030C, 1, 32'h308,       32'h308));
        // slow memory: ack every third cycle
        tbl.push_back(mk(1, 0, 32'h0000_0000, 0, 32'h0,         1,   0, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0C00_0003, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0C00_0003, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0004, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'hC000_0003, 0, 32'h0,         1,   1, 32'h0000_0004, 0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0008, 1, 32'hC000_0003, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0000_0000, 0, 32'h0,         1,   1, 32'h0000_0008, 0, 32'h0,         32'h0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst              = tbl[i].rst;
            if1.imem_ack     = tbl[i].ack;
            if1.imem_rdata   = tbl[i].rdata;
            if1.redirect     = tbl[i].redir;
            if1.redirect_pc  = tbl[i].rpc;
            if1.instr_ready  = tbl[i].ready;
            #1;
            check($sformatf("v%0d req", i),   {31'b0, if1.imem_req},    {31'b0, tbl[i].e_req});
            check($sformatf("v%0d addr", i),  if1.imem_addr,            tbl[i].e_addr);
            check($sformatf("v%0d valid", i), {31'b0, if1.instr_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid || tbl[i].rst) begin
                check($sformatf("v%0d instr", i), if1.instr,    tbl[i].e_instr);
                check($sformatf("v%0d pc", i),    if1.instr_pc, tbl[i].e_pc);
            end
        end

        // Asynchronous reset mid-request with ack held high.
        @(negedge clk);
        if1.imem_ack = 1'b1; if1.imem_rdata = 32'h0000_0011; if1.instr_ready = 1'b0;
        @(negedge clk);
        if1.imem_rdata = 32'h0000_0022;
        @(negedge clk);
        #1;
        check("fill req", {31'b0, if1.imem_req}, 32'h0);
        check("fill pc", if1.instr_pc, 32'h8);
        check("fill instr", if1.instr, 32'h11);
        check("fill mode", {30'b0, mode1}, 32'h2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst valid", {31'b0, if1.instr_valid}, 32'h0);
        check("arst req", {31'b0, if1.imem_req}, 32'h0);
        check("arst addr", if1.imem_addr, 32'h0);
        check("arst instr", if1.instr, 32'h0);
        check("arst pc", if1.instr_pc, 32'h0);
        check("arst mode", {30'b0, mode1}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if1.imem_rdata = 32'h5A5A_0000;
        #1;
        check("post req", {31'b0, if1.imem_req}, 32'h1);
        check("post addr", if1.imem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("post valid", {31'b0, if1.instr_valid}, 32'h1);
        check("post pc", if1.instr_pc, 32'h0);
        check("post instr", if1.instr, 32'h5A5A_0000);

        // PC wrap at the top of memory, and the four-entry queue filling up.
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("wrap addr0", if2.imem_addr, 32'hFFFF_FFF8);
        check("wrap valid0", {31'b0, if2.instr_valid}, 32'h0);
        check("d4 mode0", {30'b0, mode3}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wrap pc%0d", k), if2.instr_pc, 32'hFFFF_FFF8 + 32'(4 * k));
            check($sformatf("wrap instr%0d", k), if2.instr, 32'hFFFF_FFF8 + 32'(4 * k));
            check($sformatf("d4 req%0d", k), {31'b0, if3.imem_req}, (k < 3) ? 32'h1 : 32'h0);
            check($sformatf("d4 addr%0d", k), if3.imem_addr, 32'(4 * (k + 1)));
            check($sformatf("d4 head%0d", k), if3.instr_pc, 32'h0);
            check($sformatf("d4 mode%0d", k + 1), {30'b0, mode3}, (k < 3) ? 32'h1 : 32'h2);
        end
        if3.instr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            check($sformatf("d4 drain valid%0d", j), {31'b0, if3.instr_valid}, 32'h1);
            check($sformatf("d4 drain pc%0d", j), if3.instr_pc, 32'(4 * (j + 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
